egg_timer_ctrl: RTL and testbench

EGG_TIMER_CTRL -- requirements
Module: egg_timer_ctrl

---
 rtl/egg_timer_pkg.sv | 14 +
 rtl/tick_prescaler.sv | 35 +++
 rtl/egg_timer_ctrl.sv | 150 +++++++++++++++
 tb/tb_egg_timer_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/egg_timer_pkg.sv
// Shared state type and encodings for the egg timer controller.
package egg_timer_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 3'd0,
        ST_LOADED = 3'd1,
        ST_RUN    = 3'd2,
        ST_PAUSE  = 3'd3,
        ST_ALARM  = 3'd4
    } state_t;

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk by DIV while run is high; tick marks the final count of each period.
module tick_prescaler #(
    parameter int unsigned DIV = 100000000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic run,
    input  logic clr,
    output logic tick
);

    localparam int unsigned W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [W-1:0] r_cnt;
    logic         w_at_top;

    assign w_at_top = (r_cnt == W'(DIV - 1));
    // Tick is qualified by run so a held value at DIV-1 cannot emit twice.
    assign tick     = run && w_at_top;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (run) begin
            if (w_at_top) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/egg_timer_ctrl.sv
// Egg timer control FSM: button edges, countdown tick generation, alarm drive.
// Optional alarm blinking is enabled by defining EGG_TIMER_ALARM_BLINK_EN.
module egg_timer_ctrl
    import egg_timer_pkg::*;
#(
    parameter int unsigned TICK_DIV  = 100000000,
    parameter int unsigned BLINK_DIV = 25000000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       btn_load,
    input  logic       btn_start,
    input  logic       btn_clear,
    input  logic       cnt_done,
    output logic       cnt_load,
    output logic       cnt_str,
    output logic       cnt_enable,
    output logic       cnt_reset,
    output logic       alarm,
    output logic [2:0] state
);

    state_t r_state;
    logic   r_load_prev, r_start_prev, r_clear_prev;
    logic   r_cnt_load, r_cnt_reset, r_cnt_str, r_alarm;
    logic   w_load_edge, w_start_edge, w_clear_edge;
    logic   w_presc_run, w_presc_clr, w_tick;

    assign w_load_edge  = btn_load  & ~r_load_prev;
    assign w_start_edge = btn_start & ~r_start_prev;
    assign w_clear_edge = btn_clear & ~r_clear_prev;

    // Prescaler advances only on RUN cycles that stay in RUN.
    assign w_presc_run = (r_state == ST_RUN) && !w_clear_edge && !w_start_edge && !cnt_done;
    assign w_presc_clr = (r_state != ST_RUN) && (r_state != ST_PAUSE);

    tick_prescaler #(
        .DIV (TICK_DIV)
    ) u_tick_prescaler (
        .clk     (clk),
        .reset_n (reset_n),
        .run     (w_presc_run),
        .clr     (w_presc_clr),
        .tick    (w_tick)
    );

`ifdef EGG_TIMER_ALARM_BLINK_EN
    localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    logic [BW-1:0] r_blink_cnt;
`else
    logic w_unused_blink;
    assign w_unused_blink = (BLINK_DIV > 0);
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_load_prev  <= 1'b0;
            r_start_prev <= 1'b0;
            r_clear_prev <= 1'b0;
            r_cnt_load   <= 1'b0;
            r_cnt_reset  <= 1'b0;
            r_cnt_str    <= 1'b0;
            r_alarm      <= 1'b0;
`ifdef EGG_TIMER_ALARM_BLINK_EN
            r_blink_cnt  <= '0;
`endif
        end else begin
            r_load_prev  <= btn_load;
            r_start_prev <= btn_start;
            r_clear_prev <= btn_clear;
            r_cnt_load   <= 1'b0;
            r_cnt_reset  <= 1'b0;
            r_cnt_str    <= 1'b0;
            r_alarm      <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_load_edge && !w_clear_edge) begin
                        r_state     <= ST_LOADED;
                        r_cnt_load  <= 1'b1;
                        r_cnt_reset <= 1'b1;
                    end
                end
                ST_LOADED: begin
                    if (w_clear_edge) begin
                        r_state <= ST_IDLE;
                    end else if (w_start_edge) begin
                        r_state   <= ST_RUN;
                        r_cnt_str <= 1'b1;
                    end else if (w_load_edge) begin
                        r_cnt_load  <= 1'b1;
                        r_cnt_reset <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (w_clear_edge) begin
                        r_state     <= ST_IDLE;
                        r_cnt_reset <= 1'b1;
                    end else if (cnt_done) begin
                        r_state <= ST_ALARM;
                        r_alarm <= 1'b1;
`ifdef EGG_TIMER_ALARM_BLINK_EN
                        r_blink_cnt <= '0;
`endif
                    end else if (w_start_edge) begin
                        r_state <= ST_PAUSE;
                    end else begin
                        r_cnt_str <= 1'b1;
                    end
                end
                ST_PAUSE: begin
                    if (w_clear_edge) begin
                        r_state     <= ST_IDLE;
                        r_cnt_reset <= 1'b1;
                    end else if (w_start_edge) begin
                        r_state   <= ST_RUN;
                        r_cnt_str <= 1'b1;
                    end
                end
                ST_ALARM: begin
                    if (w_clear_edge || w_start_edge) begin
                        r_state     <= ST_IDLE;
                        r_cnt_reset <= 1'b1;
                    end else begin
`ifdef EGG_TIMER_ALARM_BLINK_EN
                        if (r_blink_cnt == BW'(BLINK_DIV - 1)) begin
                            r_blink_cnt <= '0;
                            r_alarm     <= ~r_alarm;
                        end else begin
                            r_blink_cnt <= r_blink_cnt + 1'b1;
                            r_alarm     <= r_alarm;
                        end
`else
                        r_alarm <= 1'b1;
`endif
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign cnt_load   = r_cnt_load;
    assign cnt_reset  = r_cnt_reset;
    assign cnt_str    = r_cnt_str;
    assign cnt_enable = w_tick;
    assign alarm      = r_alarm;
    assign state      = r_state;

endmodule

// File: tb/tb_egg_timer_ctrl.sv
// Randomized and directed bench for egg_timer_ctrl against a cycle-level behavioural model.
module tb_egg_timer_ctrl;

    localparam int TD = 4;
    localparam int BD = 3;

    logic       clk       = 1'b0;
    logic       reset_n   = 1'b1;
    logic       btn_load  = 1'b0;
    logic       btn_start = 1'b0;
    logic       btn_clear = 1'b0;
    logic       cnt_done  = 1'b0;
    logic       cnt_load, cnt_str, cnt_enable, cnt_reset, alarm;
    logic [2:0] state;

    always #5 clk = ~clk;

    egg_timer_ctrl #(
        .TICK_DIV  (TD),
        .BLINK_DIV (BD)
    ) u_dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .btn_load   (btn_load),
        .btn_start  (btn_start),
        .btn_clear  (btn_clear),
        .cnt_done   (cnt_done),
        .cnt_load   (cnt_load),
        .cnt_str    (cnt_str),
        .cnt_enable (cnt_enable),
        .cnt_reset  (cnt_reset),
        .alarm      (alarm),
        .state      (state)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Model: mode number, count of advancing RUN cycles since start, cycles spent in ALARM.
    int         m_state, m_runs, m_age;
    logic       m_lp, m_rp, m_pl, m_ps, m_pc;
    logic [7:0] obs;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    function automatic logic [7:0] outs_now();
        return {state, cnt_load, cnt_str, cnt_enable, cnt_reset, alarm};
    endfunction

    task automatic model_reset();
        m_state = 0; m_runs = 0; m_age = 0;
        m_lp = 1'b0; m_rp = 1'b0;
        m_pl = 1'b0; m_ps = 1'b0; m_pc = 1'b0;
    endtask

    function automatic logic [7:0] model_out();
        logic se, ce, adv, en, al;
        se  = btn_start & ~m_ps;
        ce  = btn_clear & ~m_pc;
        adv = (m_state == 2) && !ce && !se && !cnt_done;
        en  = adv && ((m_runs % TD) == TD - 1);
`ifdef EGG_TIMER_ALARM_BLINK_EN
        al  = (m_state == 4) && (((m_age / BD) % 2) == 0);
`else
        al  = (m_state == 4);
`endif
        return {3'(m_state), m_lp, (m_state == 2), en, m_rp, al};
    endfunction

    task automatic model_step();
        logic le, se, ce;
        int   nxt;
        le = btn_load  & ~m_pl;
        se = btn_start & ~m_ps;
        ce = btn_clear & ~m_pc;
        nxt = m_state;
        m_lp = 1'b0;
        m_rp = 1'b0;
        case (m_state)
            0: if (!ce && le) begin nxt = 1; m_lp = 1'b1; m_rp = 1'b1; end
            1: begin
                if (ce) nxt = 0;
                else if (se) begin nxt = 2; m_runs = 0; end
                else if (le) begin m_lp = 1'b1; m_rp = 1'b1; end
            end
            2: begin
                if (ce) begin nxt = 0; m_rp = 1'b1; end
                else if (cnt_done) nxt = 4;
                else if (se) nxt = 3;
                else m_runs++;
            end
            3: begin
                if (ce) begin nxt = 0; m_rp = 1'b1; end
                else if (se) nxt = 2;
            end
            default: if (ce || se) begin nxt = 0; m_rp = 1'b1; end
        endcase
        m_age   = (nxt == 4 && m_state == 4) ? m_age + 1 : 0;
        m_state = nxt;
        m_pl = btn_load; m_ps = btn_start; m_pc = btn_clear;
    endtask

    task automatic step(input logic l, input logic s, input logic c, input logic d);
        btn_load = l; btn_start = s; btn_clear = c; cnt_done = d;
        @(negedge clk);
        obs = outs_now();
        check_eq($sformatf("cyc%0d", cyc), 32'(obs), 32'(model_out()));
        model_step();
        cyc++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [11:0] tmask;
        logic [5:0]  amask;
        int          ecnt;

        model_reset();
        #1 reset_n = 1'b0;
        #2 check_eq("reset", 32'(outs_now()), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #2 reset_n = 1'b1;
        step(0, 0, 0, 0);
        $display("reset: outputs idle");

        // Load: one-cycle load+reset pulse, LOADED.
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        check_eq("s1_load", 32'({obs[7:5], obs[4], obs[1]}), 32'(5'b001_1_1));
        step(0, 0, 0, 0);
        check_eq("s1_pulse_len", 32'({obs[4], obs[1]}), 32'd0);
        $display("load: state=%0d", obs[7:5]);

        // Start and hold: ticks on RUN cycles 4, 8, 12.
        step(0, 1, 0, 0);
        for (int k = 0; k < 12; k++) begin
            step(0, 1, 0, 0);
            tmask[k] = obs[2];
        end
        check_eq("s2_ticks", 32'(tmask), 32'h888);
        $display("run: tick mask=%03h", tmask);

        // Pause with prescaler at 2, resume, tick on the second RUN cycle.
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        ecnt = 0;
        for (int k = 0; k < 10; k++) begin
            step(0, 0, 0, 0);
            if (obs[2]) ecnt++;
        end
        check_eq("s3_pause_quiet", 32'(ecnt), 32'd0);
        check_eq("s3_pause_state", 32'(obs[7:5]), 32'd3);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        check_eq("s3_resume1", 32'(obs[2]), 32'd0);
        step(0, 0, 0, 0);
        check_eq("s3_resume2", 32'(obs[2]), 32'd1);
        $display("pause/resume: ticks during pause=%0d", ecnt);

        // Done on a tick cycle suppresses the tick, then ALARM.
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        check_eq("s4_done_gate", 32'(obs[2]), 32'd0);
        for (int k = 0; k < 6; k++) begin
            step(0, 0, 0, 0);
            amask[5-k] = obs[0];
        end
        check_eq("s4_state", 32'(obs[7:5]), 32'd4);
`ifdef EGG_TIMER_ALARM_BLINK_EN
        check_eq("s4_alarm", 32'(amask), 32'(6'b111000));
`else
        check_eq("s4_alarm", 32'(amask), 32'(6'b111111));
`endif
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        check_eq("s4_clear", 32'({obs[7:5], obs[1], obs[0]}), 32'(5'b000_1_0));
        $display("alarm: pattern=%06b", amask);

        // Clear and start edges together in RUN -> IDLE.
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 1, 1, 0);
        step(0, 0, 0, 0);
        check_eq("s5_clear_prio", 32'(obs[7:5]), 32'd0);
        $display("clear+start: state=%0d", obs[7:5]);

        // Async reset in RUN on a would-be tick cycle; start alone afterwards does nothing.
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        #2 reset_n = 1'b0;
        #1 check_eq("s6_async", 32'(outs_now()), 32'd0);
        model_reset();
        #10 reset_n = 1'b1;
        step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        ecnt = 0;
        for (int k = 0; k < 12; k++) begin
            step(0, 1, 0, 0);
            if (obs[2]) ecnt++;
        end
        check_eq("s6_no_tick", 32'(ecnt), 32'd0);
        $display("reset mid-run: ticks after bare start=%0d", ecnt);

        // Random button activity.
        begin
            logic l, s, c;
            l = 1'b0; s = 1'b0; c = 1'b0;
            for (int k = 0; k < 2000; k++) begin
                if ($urandom_range(0, 3) == 0)  l = ~l;
                if ($urandom_range(0, 3) == 0)  s = ~s;
                if ($urandom_range(0, 11) == 0) c = ~c;
                step(l, s, c, ($urandom_range(0, 19) == 0));
            end
        end
        $display("random: %0d cycles", 2000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
